bus_rr_arbit: RTL and testbench

- Parametrised shared bus: NUM_M masters and NUM_S slaves, generalising the fixed 2-master/2-slave bus.
- Registered round-robin arbiter with an anti-starvation hold limit (MAX_HOLD).
- Muxes the granted master onto a common slave address/write/data path and decodes slave select from the upper address bits.
- Returns read data through a one-cycle registered slave-select; unmapped accesses read 0 and raise a registered decode-error flag.

---
 rtl/bus_rr_arbit_if.sv | 31 +++
 rtl/bus_rr_arbit.sv | 113 +++++++++++
 tb/tb_bus_rr_arbit.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbit_if.sv
// Shared-bus signal bundle for bus_rr_arbit: the master modport is the view of the
// attached masters and slaves, the slave modport is the arbiter/mux fabric itself.
interface bus_rr_arbit_if #(
    parameter int NUM_M = 2,
    parameter int NUM_S = 2,
    parameter int AW    = 8,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_wr;
    logic [NUM_M*AW-1:0] m_address;
    logic [NUM_M*DW-1:0] m_dout;
    logic [NUM_M-1:0]    m_grant;
    logic [DW-1:0]       m_din;
    logic [NUM_S-1:0]    s_sel;
    logic [AW-1:0]       s_address;
    logic                s_wr;
    logic [DW-1:0]       s_din;
    logic [NUM_S*DW-1:0] s_dout;
    logic                dec_err;

    modport master (
        output m_req, m_wr, m_address, m_dout, s_dout,
        input  m_grant, m_din, s_sel, s_address, s_wr, s_din, dec_err
    );

    modport slave (
        input  m_req, m_wr, m_address, m_dout, s_dout,
        output m_grant, m_din, s_sel, s_address, s_wr, s_din, dec_err
    );
endinterface

// File: rtl/bus_rr_arbit.sv
// Round-robin shared bus: registered arbiter with a contended-hold limit, address
// decode onto NUM_S slaves, registered read-select return path and decode-error flag.
module bus_rr_arbit #(
    parameter int NUM_M    = 2,
    parameter int NUM_S    = 2,
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_rr_arbit_if.slave   bus
);
    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [SEL_W:0]   NUM_S_L    = (SEL_W+1)'(NUM_S);
    localparam logic [HW:0]      MAX_HOLD_L = (HW+1)'(MAX_HOLD);
    localparam logic [HW-1:0]    HOLD_SAT_L = {HW{1'b1}};
    localparam logic [NUM_M-1:0] PARK_L     = {{(NUM_M-1){1'b0}}, 1'b1};

    logic [GW-1:0]    g_r;
    logic [NUM_M-1:0] grant_r;
    logic [HW-1:0]    hold_r;
    logic [NUM_S-1:0] rd_sel_r;
    logic             dec_err_r;

    logic             req_g_s;
    logic             other_s;
    logic             hit_s;
    logic             limit_s;
    logic [AW-1:0]    addr_s;
    logic [SEL_W-1:0] idx_s;
    logic [NUM_S-1:0] sel_s;
    logic [DW-1:0]    din_s;
    logic [GW-1:0]    cand_s;
    logic [GW-1:0]    rot_s;
    logic [GW-1:0]    g_nxt_s;
    logic [HW-1:0]    hold_inc_s;
    logic [HW-1:0]    hold_nxt_s;

    // Granted-master mux and slave-index decode
    always_comb begin
        req_g_s = bus.m_req[g_r];
        addr_s  = bus.m_address[g_r*AW +: AW];
        idx_s   = addr_s[AW-1 -: SEL_W];
        hit_s   = ({1'b0, idx_s} < NUM_S_L);
        sel_s   = {NUM_S{1'b0}};
        for (int j = 0; j < NUM_S; j++) begin
            sel_s[j] = req_g_s & hit_s & (idx_s == SEL_W'(j));
        end
    end

    // Read return: rd_sel_r is one-hot or zero, so an AND-OR mux suffices
    always_comb begin
        din_s = {DW{1'b0}};
        for (int j = 0; j < NUM_S; j++) begin
            din_s = din_s | (bus.s_dout[j*DW +: DW] & {DW{rd_sel_r[j]}});
        end
    end

    // Next owner and hold count; the nearest requester after g wins the rotation
    always_comb begin
        other_s = |(bus.m_req & ~grant_r);
        rot_s   = g_r;
        cand_s  = g_r;
        for (int k = NUM_M - 1; k >= 1; k--) begin
            cand_s = GW'((int'(g_r) + k) % NUM_M);
            rot_s  = bus.m_req[cand_s] ? cand_s : rot_s;
        end
        hold_inc_s = (hold_r == HOLD_SAT_L) ? hold_r : hold_r + HW'(1);
        limit_s    = (MAX_HOLD != 0) && (({1'b0, hold_r} + (HW+1)'(1)) >= MAX_HOLD_L);
        g_nxt_s    = g_r;
        hold_nxt_s = {HW{1'b0}};
        case ({req_g_s, other_s})
            2'b10: hold_nxt_s = hold_inc_s;
            2'b11: begin
                if (limit_s) begin
                    g_nxt_s = rot_s;
                end else begin
                    hold_nxt_s = hold_inc_s;
                end
            end
            2'b01:   g_nxt_s = rot_s;
            default: g_nxt_s = g_r;
        endcase
    end

    // Arbiter state, registered grant, read select and decode error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_r       <= {GW{1'b0}};
            grant_r   <= PARK_L;
            hold_r    <= {HW{1'b0}};
            rd_sel_r  <= {NUM_S{1'b0}};
            dec_err_r <= 1'b0;
        end else begin
            g_r       <= g_nxt_s;
            grant_r   <= PARK_L << g_nxt_s;
            hold_r    <= hold_nxt_s;
            rd_sel_r  <= sel_s;
            dec_err_r <= req_g_s & ~hit_s;
        end
    end

    assign bus.m_grant   = grant_r;
    assign bus.m_din     = din_s;
    assign bus.s_sel     = sel_s;
    assign bus.s_address = addr_s;
    assign bus.s_wr      = bus.m_wr[g_r] & req_g_s;
    assign bus.s_din     = bus.m_dout[g_r*DW +: DW];
    assign bus.dec_err   = dec_err_r;
endmodule

// File: tb/tb_bus_rr_arbit.sv
// Bench for bus_rr_arbit: directed scenarios plus randomized traffic on two instances
// (hold limit 4 and unlimited) checked against an ownership/streak reference model.
module tb_bus_rr_arbit;
    localparam int NM = 4;
    localparam int NS = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_wr;
    logic [NM*AW-1:0] m_address;
    logic [NM*DW-1:0] m_dout;
    logic [NS*DW-1:0] s_dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_rr_arbit_if #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW)) bif ();
    bus_rr_arbit_if #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW)) bif0 ();

    assign bif.m_req      = m_req;
    assign bif.m_wr       = m_wr;
    assign bif.m_address  = m_address;
    assign bif.m_dout     = m_dout;
    assign bif.s_dout     = s_dout;
    assign bif0.m_req     = m_req;
    assign bif0.m_wr      = m_wr;
    assign bif0.m_address = m_address;
    assign bif0.m_dout    = m_dout;
    assign bif0.s_dout    = s_dout;

    bus_rr_arbit #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(SW), .MAX_HOLD(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif));
    bus_rr_arbit #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(SW), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bif0));

    // Index 0 = hold limit 4, index 1 = unlimited hold
    logic [NM-1:0] grant_o [2];
    logic [DW-1:0] din_o   [2];
    logic [NS-1:0] sel_o   [2];
    logic [AW-1:0] saddr_o [2];
    logic          swr_o   [2];
    logic [DW-1:0] sdin_o  [2];
    logic          derr_o  [2];
    assign grant_o[0] = bif.m_grant;   assign grant_o[1] = bif0.m_grant;
    assign din_o[0]   = bif.m_din;     assign din_o[1]   = bif0.m_din;
    assign sel_o[0]   = bif.s_sel;     assign sel_o[1]   = bif0.s_sel;
    assign saddr_o[0] = bif.s_address; assign saddr_o[1] = bif0.s_address;
    assign swr_o[0]   = bif.s_wr;      assign swr_o[1]   = bif0.s_wr;
    assign sdin_o[0]  = bif.s_din;     assign sdin_o[1]  = bif0.s_din;
    assign derr_o[0]  = bif.dec_err;   assign derr_o[1]  = bif0.dec_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n   = 1'b0;
        m_req     = '0;
        m_wr      = '0;
        m_address = '0;
        m_dout    = '0;
        s_dout    = '0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            if (p == 1) repeat (10) tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (grant_o[i] !== 4'b0001) begin
                    failures++;
                    $display("FAIL reset_grant inst=%0d phase=%0d got=%b exp=0001", i, p, grant_o[i]);
                end
                checks++;
                if (din_o[i] !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_din inst=%0d phase=%0d got=%h exp=0", i, p, din_o[i]);
                end
                checks++;
                if (derr_o[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_dec_err inst=%0d phase=%0d got=%b exp=0", i, p, derr_o[i]);
                end
                checks++;
                if (sel_o[i] !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_s_sel inst=%0d phase=%0d got=%b exp=00", i, p, sel_o[i]);
                end
            end
        end
    endtask

    task automatic test_single_read;
        apply_reset();
        m_req = 4'b0010;
        m_address[1*AW +: AW] = 8'h40;
        s_dout = {32'hCAFE0001, 32'hDEAD0000};
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0001 || sel_o[i] !== 2'b00) begin
                failures++;
                $display("FAIL read_pre inst=%0d got grant=%b sel=%b exp grant=0001 sel=00", i, grant_o[i], sel_o[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0010) begin
                failures++;
                $display("FAIL read_grant inst=%0d got=%b exp=0010", i, grant_o[i]);
            end
            checks++;
            if (sel_o[i] !== 2'b10 || saddr_o[i] !== 8'h40) begin
                failures++;
                $display("FAIL read_sel inst=%0d got sel=%b addr=%h exp sel=10 addr=40", i, sel_o[i], saddr_o[i]);
            end
            checks++;
            if (din_o[i] !== 32'h0) begin
                failures++;
                $display("FAIL read_din_early inst=%0d got=%h exp=0", i, din_o[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (din_o[i] !== 32'hCAFE0001) begin
                failures++;
                $display("FAIL read_din inst=%0d got=%h exp=cafe0001", i, din_o[i]);
            end
        end
        m_req = 4'b0000;
    endtask

    task automatic test_round_robin;
        logic [NM-1:0] exp_g;
        apply_reset();
        m_req = 4'b1111;
        for (int n = 0; n < 20; n++) begin
            if (n > 0) tick();
            exp_g = 4'b0001 << ((n / 4) % 4);
            checks++;
            if (grant_o[0] !== exp_g) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got=%b exp=%b", n, grant_o[0], exp_g);
            end
            checks++;
            if (grant_o[1] !== 4'b0001) begin
                failures++;
                $display("FAIL rr_unlimited_grant cycle=%0d got=%b exp=0001", n, grant_o[1]);
            end
        end
    endtask

    task automatic test_unlimited_hold;
        logic [NM-1:0] exp_g;
        apply_reset();
        m_req = 4'b0011;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            exp_g = 4'b0001 << ((n / 4) % 2);
            checks++;
            if (grant_o[1] !== 4'b0001 || grant_o[0] !== exp_g) begin
                failures++;
                $display("FAIL hold_grant cycle=%0d got lim=%b unl=%b exp lim=%b unl=0001",
                         n, grant_o[0], grant_o[1], exp_g);
            end
        end
        m_req = 4'b0010;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0010) begin
                failures++;
                $display("FAIL hold_release inst=%0d got=%b exp=0010", i, grant_o[i]);
            end
        end
    endtask

    task automatic test_decode_error;
        apply_reset();
        m_req = 4'b0001;
        m_address[0 +: AW] = 8'hC0;
        s_dout = {32'h5555AAAA, 32'h1234ABCD};
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sel_o[i] !== 2'b00 || saddr_o[i] !== 8'hC0 || derr_o[i] !== 1'b0) begin
                failures++;
                $display("FAIL decerr_sel inst=%0d got sel=%b addr=%h err=%b exp sel=00 addr=c0 err=0",
                         i, sel_o[i], saddr_o[i], derr_o[i]);
            end
        end
        tick();
        m_req = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (derr_o[i] !== 1'b1 || din_o[i] !== 32'h0) begin
                failures++;
                $display("FAIL decerr_flag inst=%0d got err=%b din=%h exp err=1 din=0", i, derr_o[i], din_o[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (derr_o[i] !== 1'b0 || din_o[i] !== 32'h0) begin
                failures++;
                $display("FAIL decerr_clear inst=%0d got err=%b din=%h exp err=0 din=0", i, derr_o[i], din_o[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        apply_reset();
        m_req = 4'b0100;
        m_address[2*AW +: AW] = 8'h00;
        s_dout = {32'h0BAD0BAD, 32'h12345678};
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0100) begin
                failures++;
                $display("FAIL midrst_grant inst=%0d got=%b exp=0100", i, grant_o[i]);
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (din_o[i] !== 32'h12345678) begin
                failures++;
                $display("FAIL midrst_din inst=%0d got=%h exp=12345678", i, din_o[i]);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0001 || din_o[i] !== 32'h0 || derr_o[i] !== 1'b0) begin
                failures++;
                $display("FAIL midrst_async inst=%0d got grant=%b din=%h err=%b exp grant=0001 din=0 err=0",
                         i, grant_o[i], din_o[i], derr_o[i]);
            end
        end
        m_req = 4'b0110;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (grant_o[i] !== 4'b0010) begin
                failures++;
                $display("FAIL midrst_resume inst=%0d got=%b exp=0010", i, grant_o[i]);
            end
        end
    endtask

    // Reference: each instance tracks current owner, how long it has held the bus
    // while requesting, and which slave (if any) was addressed last cycle.
    task automatic test_random;
        int owner [2];
        int streak [2];
        int rd [2];
        logic derr_m [2];
        int lim [2];
        int cap [2];
        logic [AW-1:0] a;
        int idx;
        logic mine, others;
        logic [NS-1:0] exp_sel;
        logic [DW-1:0] exp_din;
        int nxt;
        lim[0] = 4; lim[1] = 0;
        cap[0] = 7; cap[1] = 1;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = 0; streak[i] = 0; rd[i] = -1; derr_m[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 9) < 3) m_req = 4'($urandom_range(0, 15));
            m_wr      = 4'($urandom_range(0, 15));
            m_address = $urandom;
            m_dout    = {$urandom, $urandom, $urandom, $urandom};
            s_dout    = {$urandom, $urandom};
            #1;
            for (int i = 0; i < 2; i++) begin
                a      = m_address[owner[i]*AW +: AW];
                idx    = int'(a[AW-1 -: SW]);
                mine   = m_req[owner[i]];
                others = 1'b0;
                for (int k = 0; k < NM; k++) if (k != owner[i] && m_req[k]) others = 1'b1;
                exp_sel = '0;
                if (mine && idx < NS) exp_sel[idx] = 1'b1;
                exp_din = (rd[i] >= 0) ? s_dout[rd[i]*DW +: DW] : 32'h0;
                checks++;
                if (grant_o[i] !== (4'b0001 << owner[i])) begin
                    failures++;
                    $display("FAIL rand_grant inst=%0d cyc=%0d got=%b exp owner %0d", i, cyc, grant_o[i], owner[i]);
                end
                checks++;
                if (saddr_o[i] !== a || sdin_o[i] !== m_dout[owner[i]*DW +: DW]) begin
                    failures++;
                    $display("FAIL rand_path inst=%0d cyc=%0d got addr=%h din=%h exp addr=%h din=%h",
                             i, cyc, saddr_o[i], sdin_o[i], a, m_dout[owner[i]*DW +: DW]);
                end
                checks++;
                if (swr_o[i] !== (m_wr[owner[i]] & mine)) begin
                    failures++;
                    $display("FAIL rand_s_wr inst=%0d cyc=%0d got=%b exp=%b", i, cyc, swr_o[i], m_wr[owner[i]] & mine);
                end
                checks++;
                if (sel_o[i] !== exp_sel) begin
                    failures++;
                    $display("FAIL rand_s_sel inst=%0d cyc=%0d got=%b exp=%b", i, cyc, sel_o[i], exp_sel);
                end
                checks++;
                if (din_o[i] !== exp_din) begin
                    failures++;
                    $display("FAIL rand_m_din inst=%0d cyc=%0d got=%h exp=%h", i, cyc, din_o[i], exp_din);
                end
                checks++;
                if (derr_o[i] !== derr_m[i]) begin
                    failures++;
                    $display("FAIL rand_dec_err inst=%0d cyc=%0d got=%b exp=%b", i, cyc, derr_o[i], derr_m[i]);
                end
                derr_m[i] = mine && (idx >= NS);
                rd[i]     = (mine && idx < NS) ? idx : -1;
                nxt = owner[i];
                for (int k = NM - 1; k >= 1; k--) if (m_req[(owner[i] + k) % NM]) nxt = (owner[i] + k) % NM;
                if (!mine && !others) begin
                    streak[i] = 0;
                end else if (!mine) begin
                    owner[i] = nxt; streak[i] = 0;
                end else if (others && lim[i] != 0 && streak[i] + 1 >= lim[i]) begin
                    owner[i] = nxt; streak[i] = 0;
                end else begin
                    streak[i] = (streak[i] + 1 > cap[i]) ? cap[i] : streak[i] + 1;
                end
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_unlimited_hold();
        test_decode_error();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
